// File: rtl/clk_div_pkg.sv
// Shared types and reset defaults for the multi-channel programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } ch_state_e;

  localparam int DEF_HIGH_LEN = 5;
  localparam int DEF_LOW_LEN  = 5;
  localparam int MAX_CH       = 16;

endpackage

// File: rtl/clk_div_chan.sv
// One generated-clock channel: IDLE/HIGH/LOW phase FSM with shadow and active
// length registers; new lengths only take effect at a period boundary.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_HIGH = DEF_HIGH_LEN,
  parameter int DEF_LOW  = DEF_LOW_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] RST_LOW  = CNT_W'(DEF_LOW);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  ch_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] act_high_reg;
  logic [CNT_W-1:0] act_low_reg;
  logic [CNT_W-1:0] shd_high_reg;
  logic [CNT_W-1:0] shd_low_reg;
  logic             pending_reg;
  logic             pending_next;
  logic             clk_out_reg;
  logic             rise_reg;

  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             high_done;
  logic             low_done;
  logic             boundary;

  // A zero-length phase still occupies one cycle
  assign high_len  = (act_high_reg == '0) ? ONE : act_high_reg;
  assign low_len   = (act_low_reg == '0) ? ONE : act_low_reg;
  assign high_done = (cnt_reg == high_len);
  assign low_done  = (cnt_reg == low_len);

  always_comb begin
    boundary = 1'b0;
    if (en) begin
      case (state_reg)
        IDLE:    boundary = 1'b1;
        LOW:     boundary = low_done;
        default: boundary = 1'b0;
      endcase
    end
  end

  // A write landing on a boundary cycle stays pending for the following period
  always_comb begin
    pending_next = pending_reg;
    if (cfg_wr) begin
      pending_next = 1'b1;
    end else if (boundary) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      clk_out_reg <= 1'b0;
      rise_reg    <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      if (!en) begin
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        clk_out_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg   <= HIGH;
            cnt_reg     <= ONE;
            clk_out_reg <= 1'b1;
            rise_reg    <= 1'b1;
          end
          HIGH: begin
            if (high_done) begin
              state_reg   <= LOW;
              cnt_reg     <= ONE;
              clk_out_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + ONE;
            end
          end
          LOW: begin
            if (low_done) begin
              state_reg   <= HIGH;
              cnt_reg     <= ONE;
              clk_out_reg <= 1'b1;
              rise_reg    <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + ONE;
            end
          end
          default: begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_high_reg <= RST_HIGH;
      act_low_reg  <= RST_LOW;
      shd_high_reg <= RST_HIGH;
      shd_low_reg  <= RST_LOW;
      pending_reg  <= 1'b0;
    end else begin
      if (boundary) begin
        act_high_reg <= shd_high_reg;
        act_low_reg  <= shd_low_reg;
      end
      if (cfg_wr) begin
        shd_high_reg <= cfg_high;
        shd_low_reg  <= cfg_low;
      end
      pending_reg <= pending_next;
    end
  end

  assign clk_out    = clk_out_reg;
  assign rise_pulse = rise_reg;
  assign pending    = pending_reg;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider: configuration demux and back-pressure in front
// of NUM_CH independent clk_div_chan instances.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int DEF_HIGH = DEF_HIGH_LEN,
  parameter int DEF_LOW  = DEF_LOW_LEN,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_pulse
);

  localparam int SLOTS = 1 << CH_W;

  logic [NUM_CH-1:0] pending;
  logic [SLOTS-1:0]  pending_slot;
  logic              cfg_accept;

  // Unpopulated channel indices never back-pressure, so writes to them drain away
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_CH) begin : g_real
        assign pending_slot[gi] = pending[gi];
      end else begin : g_void
        assign pending_slot[gi] = 1'b0;
      end
    end
  endgenerate

  assign cfg_ready  = ~pending_slot[cfg_ch];
  assign cfg_accept = cfg_valid & cfg_ready;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      clk_div_chan #(
        .CNT_W    (CNT_W),
        .DEF_HIGH (DEF_HIGH),
        .DEF_LOW  (DEF_LOW)
      ) u_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (ch_en[gi]),
        .cfg_wr     (cfg_accept && (cfg_ch == CH_W'(gi))),
        .cfg_high   (cfg_high),
        .cfg_low    (cfg_low),
        .clk_out    (clk_out[gi]),
        .rise_pulse (rise_pulse[gi]),
        .pending    (pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus random traffic
// against a period-position reference model.
module tb_clk_div_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_high = '0;
  logic [CNT_W-1:0]  cfg_low = '0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] rise_pulse;

  always #5 clk = ~clk;

  clk_div_gen #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DEF_HIGH (5),
    .DEF_LOW  (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_high   (cfg_high),
    .cfg_low    (cfg_low),
    .ch_en      (ch_en),
    .clk_out    (clk_out),
    .rise_pulse (rise_pulse)
  );

  int checks = 0;
  int errors = 0;
  logic [NUM_CH-1:0] cur_en = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each running channel is a position (age) inside a period
  // of eff(high)+eff(low) cycles; lengths are latched at age 0.
  int m_act_h[NUM_CH];
  int m_act_l[NUM_CH];
  int m_shd_h[NUM_CH];
  int m_shd_l[NUM_CH];
  int m_age[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_run[NUM_CH];

  function automatic int eff(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_act_h[i] = 5; m_act_l[i] = 5;
      m_shd_h[i] = 5; m_shd_l[i] = 5;
      m_age[i] = 0; m_pend[i] = 0; m_run[i] = 0;
    end
  endfunction

  function automatic bit model_ready(input int ch);
    return (ch >= NUM_CH) || !m_pend[ch];
  endfunction

  function automatic void model_clock(input logic [NUM_CH-1:0] en, input bit acc,
                                      input int ch, input int h, input int l);
    for (int i = 0; i < NUM_CH; i++) begin
      if (!en[i]) begin
        m_run[i] = 0;
      end else if (!m_run[i]) begin
        m_run[i] = 1; m_age[i] = 0;
        m_act_h[i] = m_shd_h[i]; m_act_l[i] = m_shd_l[i]; m_pend[i] = 0;
      end else begin
        m_age[i]++;
        if (m_age[i] == eff(m_act_h[i]) + eff(m_act_l[i])) begin
          m_age[i] = 0;
          m_act_h[i] = m_shd_h[i]; m_act_l[i] = m_shd_l[i]; m_pend[i] = 0;
        end
      end
    end
    if (acc && ch < NUM_CH) begin
      m_shd_h[ch] = h; m_shd_l[ch] = l; m_pend[ch] = 1;
    end
  endfunction

  function automatic logic [NUM_CH-1:0] model_clk();
    logic [NUM_CH-1:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_run[i] && (m_age[i] < eff(m_act_h[i]));
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] model_rise();
    logic [NUM_CH-1:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_run[i] && (m_age[i] == 0);
    return v;
  endfunction

  // One clock cycle: called and returns at a falling edge.
  task automatic step(input bit v, input int ch, input int h, input int l);
    bit acc;
    cfg_valid = v; cfg_ch = CH_W'(ch); cfg_high = CNT_W'(h); cfg_low = CNT_W'(l);
    ch_en = cur_en;
    #1;
    check_eq("cfg_ready", cfg_ready, model_ready(ch));
    acc = v && model_ready(ch);
    @(posedge clk);
    model_clock(cur_en, acc, ch, h, l);
    @(negedge clk);
    check_eq("clk_out", clk_out, model_clk());
    check_eq("rise_pulse", rise_pulse, model_rise());
    cfg_valid = 1'b0;
  endtask

  task automatic steps_to_rise(input int chn, input int limit, output int n);
    n = 0;
    do begin
      step(0, 0, 0, 0);
      n++;
    end while (!rise_pulse[chn] && n < limit);
    if (!rise_pulse[chn]) check_eq("rise_timeout", rise_pulse[chn], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] pat;
    int n;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_clk_out", clk_out, 0);
    check_eq("rst_rise", rise_pulse, 0);
    check_eq("rst_ready", cfg_ready, 1);
    @(negedge clk);

    // Default 5/5 on ch0 straight out of reset
    cur_en = 4'b0001; ch_en = cur_en; rst_n = 1'b1;
    pat = '0;
    for (int i = 0; i < 10; i++) begin step(0, 0, 0, 0); pat = {pat[18:0], clk_out[0]}; end
    check_eq("default_5_5", pat[9:0], 10'b1111100000);

    // Update accepted mid-HIGH lands only after the running period
    step(0, 0, 0, 0);
    step(1, 0, 2, 3);
    check_eq("ready_after_accept", cfg_ready, 0);
    pat = '0;
    for (int i = 0; i < 13; i++) begin step(0, 0, 0, 0); pat = {pat[18:0], clk_out[0]}; end
    check_eq("boundary_update", pat[12:0], 13'b1110000011000);
    check_eq("ready_after_apply", cfg_ready, 1);

    // Zero lengths give period 2, max lengths give 510
    step(1, 0, 0, 0);
    steps_to_rise(0, 20, n);
    steps_to_rise(0, 20, n);
    check_eq("period_min", n, 2);
    step(1, 0, 255, 255);
    steps_to_rise(0, 20, n);
    steps_to_rise(0, 600, n);
    check_eq("period_max", n, 510);

    // Disable ch1 mid-LOW, then re-enable
    cur_en = 4'b0011;
    n = 0;
    do begin step(0, 0, 0, 0); n++; end
    while (!(m_run[1] && m_age[1] >= eff(m_act_h[1])) && n < 30);
    cur_en[1] = 1'b0;
    step(0, 0, 0, 0);
    check_eq("disable_clk", clk_out[1], 0);
    repeat (3) step(0, 0, 0, 0);
    cur_en[1] = 1'b1;
    step(0, 0, 0, 0);
    check_eq("reenable_rise", rise_pulse[1], 1);
    n = 1;
    while (clk_out[1] && n < 300) begin
      step(0, 0, 0, 0);
      if (clk_out[1]) n++;
    end
    check_eq("reenable_high_len", n, 5);

    // Asynchronous reset while ch0 is HIGH with an update pending
    cur_en = 4'b0001;
    steps_to_rise(0, 600, n);
    step(1, 0, 7, 9);
    check_eq("pend_before_rst", cfg_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_clk_out", clk_out, 0);
    check_eq("async_rise", rise_pulse, 0);
    check_eq("async_ready", cfg_ready, 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pat = '0;
    for (int i = 0; i < 20; i++) begin step(0, 0, 0, 0); pat = {pat[18:0], clk_out[0]}; end
    check_eq("post_rst_5_5", pat, 20'b11111000001111100000);

    // ch0 and ch2 hit a boundary together while ch3 is configured
    cur_en = 4'b0101;
    step(0, 0, 0, 0);
    n = 0;
    while (m_age[0] != 9 && n < 30) begin step(0, 0, 0, 0); n++; end
    step(1, 3, 4, 4);
    check_eq("conc_rise", rise_pulse & 4'b0101, 4'b0101);
    check_eq("conc_ch3_pending", cfg_ready, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bit v;
      int ch, h, l;
      if ($urandom_range(0, 99) < 3) cur_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      v  = ($urandom_range(0, 99) < 30);
      ch = $urandom_range(0, NUM_CH - 1);
      h  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 6) : $urandom_range(0, 40);
      l  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 6) : $urandom_range(0, 40);
      step(v, ch, h, l);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
